conv1d_engine: RTL and testbench



---
 rtl/conv1d_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_conv1d_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_engine.sv
// conv1d_engine: signed 1-D "valid" convolution engine that owns the single-port SRAM while busy.
// Weights and a sliding sample window are held in registers, and one output is produced every three cycles.
module conv1d_engine #(
  parameter int NumWords  = 128,
  parameter int KMax      = 8,
  parameter int DataWidth = 32,
  parameter int AddrWidth = $clog2(NumWords),
  parameter int KW        = $clog2(KMax) + 1,
  parameter int AccWidth  = 2 * DataWidth + $clog2(KMax)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [AddrWidth-1:0] in_base_i,
  input  logic [AddrWidth-1:0] w_base_i,
  input  logic [AddrWidth-1:0] out_base_i,
  input  logic [AddrWidth:0]   in_len_i,
  input  logic [KW-1:0]        k_len_i,
  input  logic [5:0]           shift_i,
  input  logic                 sat_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 ext_gnt_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);
  localparam int EW = AddrWidth + 2;
  typedef logic [EW-1:0] ext_t;
  localparam ext_t Depth = ext_t'(NumWords);
  localparam ext_t EOne = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] KOne = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] KMaxV = KW'(KMax);
  localparam logic [AddrWidth:0] IOne = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] AOne = {{(AddrWidth-1){1'b0}}, 1'b1};
  localparam logic signed [AccWidth-1:0] SatMax = {{(AccWidth-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [AccWidth-1:0] SatMin = {{(AccWidth-32){1'b1}}, 32'h8000_0000};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDW   = 3'd1,
    PRIME = 3'd2,
    RD    = 3'd3,
    CAP   = 3'd4,
    WR    = 3'd5,
    FIN   = 3'd6
  } state_e;

  function automatic logic signed [AccWidth-1:0] sext(input logic signed [DataWidth-1:0] v);
    return {{(AccWidth-DataWidth){v[DataWidth-1]}}, v};
  endfunction

  state_e                       state_r, state_n;
  logic [AddrWidth-1:0]         in_base_r, w_base_r, out_base_r;
  logic [AddrWidth:0]           n_r, idx_r;
  logic [KW-1:0]                k_r, cnt_r;
  logic [5:0]                   shift_r;
  logic                         sat_r, err_r;
  logic signed [DataWidth-1:0]  w_r [KMax];
  logic signed [DataWidth-1:0]  win_r [KMax];
  logic signed [DataWidth-1:0]  win_nx_s [KMax];
  logic signed [DataWidth-1:0]  sample_s;
  logic [KW-1:0]                k_top_s;
  ext_t                         n_cfg_s;
  logic                         cfg_bad_s, active_s;
  logic signed [AccWidth-1:0]   acc_s, shd_s;
  logic [31:0]                  y_s;

  assign sample_s  = mem_rdata_i[DataWidth-1:0];
  assign k_top_s   = k_r - KOne;
  assign active_s  = (state_r != IDLE) && (state_r != FIN);
  assign busy_o    = active_s;
  assign ext_gnt_o = !active_s;
  assign done_o    = (state_r == FIN);
  assign err_o     = err_r;

  // Configuration check on the live inputs, evaluated in the start cycle.
  always_comb begin
    n_cfg_s   = ext_t'(in_len_i) - ext_t'(k_len_i) + EOne;
    cfg_bad_s = (k_len_i == '0) || (k_len_i > KMaxV) ||
                (ext_t'(in_len_i) < ext_t'(k_len_i)) ||
                (ext_t'(in_base_i) + ext_t'(in_len_i) > Depth) ||
                (ext_t'(w_base_i) + ext_t'(k_len_i) > Depth) ||
                (ext_t'(out_base_i) + n_cfg_s > Depth);
  end

  // Window shifted down by one with the fresh sample landing in tap K-1.
  always_comb begin
    for (int k = 0; k < KMax; k++) begin
      win_nx_s[k] = win_r[k];
    end
    for (int k = 0; k < KMax - 1; k++) begin
      if (KW'(k) < k_top_s) begin
        win_nx_s[k] = win_r[k+1];
      end else begin
        win_nx_s[k] = win_r[k];
      end
    end
    for (int k = 0; k < KMax; k++) begin
      if (KW'(k) == k_top_s) begin
        win_nx_s[k] = sample_s;
      end else begin
        win_nx_s[k] = win_nx_s[k];
      end
    end
  end

  // Output sample: dot product, arithmetic shift, optional clamp.
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < KMax; k++) begin
      acc_s = acc_s + sext(w_r[k]) * sext(win_r[k]);
    end
    shd_s = acc_s >>> shift_r;
    if (sat_r && (shd_s > SatMax)) begin
      y_s = 32'h7FFF_FFFF;
    end else if (sat_r && (shd_s < SatMin)) begin
      y_s = 32'h8000_0000;
    end else begin
      y_s = shd_s[31:0];
    end
  end

  // Next-state logic; an abort overrides every active state.
  always_comb begin
    state_n = state_r;
    if (abort_i && active_s) begin
      state_n = FIN;
    end else begin
      case (state_r)
        IDLE:    state_n = start_i ? (cfg_bad_s ? FIN : LDW) : IDLE;
        LDW:     state_n = (cnt_r == k_r) ? ((k_r > KOne) ? PRIME : RD) : LDW;
        PRIME:   state_n = (cnt_r == k_top_s) ? RD : PRIME;
        RD:      state_n = CAP;
        CAP:     state_n = WR;
        WR:      state_n = (idx_r == n_r - IOne) ? FIN : RD;
        FIN:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // SRAM request decode; reads are issued one cycle ahead of their capture.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0000_0000;
    if (abort_i) begin
      mem_req_o = 1'b0;
    end else begin
      case (state_r)
        LDW: begin
          if (cnt_r < k_r) begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_base_r + AddrWidth'(cnt_r);
          end else begin
            mem_req_o = 1'b0;
          end
        end
        PRIME: begin
          if (cnt_r < k_top_s) begin
            mem_req_o  = 1'b1;
            mem_addr_o = in_base_r + AddrWidth'(cnt_r);
          end else begin
            mem_req_o = 1'b0;
          end
        end
        RD: begin
          mem_req_o  = 1'b1;
          mem_addr_o = in_base_r + AddrWidth'(idx_r) + AddrWidth'(k_r) - AOne;
        end
        WR: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = out_base_r + AddrWidth'(idx_r);
          mem_wdata_o = y_s;
        end
        default: mem_req_o = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Configuration latch, counters, weight and window registers, status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_base_r  <= '0;
      w_base_r   <= '0;
      out_base_r <= '0;
      n_r        <= '0;
      idx_r      <= '0;
      k_r        <= '0;
      cnt_r      <= '0;
      shift_r    <= 6'd0;
      sat_r      <= 1'b0;
      err_r      <= 1'b0;
      for (int k = 0; k < KMax; k++) begin
        w_r[k]   <= '0;
        win_r[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            in_base_r  <= in_base_i;
            w_base_r   <= w_base_i;
            out_base_r <= out_base_i;
            n_r        <= n_cfg_s[AddrWidth:0];
            k_r        <= k_len_i;
            shift_r    <= shift_i;
            sat_r      <= sat_i;
            err_r      <= cfg_bad_s;
            cnt_r      <= '0;
            idx_r      <= '0;
            for (int k = 0; k < KMax; k++) begin
              w_r[k]   <= '0;
              win_r[k] <= '0;
            end
          end
        end
        LDW: begin
          cnt_r <= (cnt_r == k_r) ? '0 : cnt_r + KOne;
          for (int k = 0; k < KMax; k++) begin
            if ((cnt_r != '0) && (KW'(k) == cnt_r - KOne)) begin
              w_r[k] <= sample_s;
            end
          end
        end
        PRIME: begin
          cnt_r <= cnt_r + KOne;
          if (cnt_r != '0) begin
            win_r <= win_nx_s;
          end
        end
        CAP:     win_r <= win_nx_s;
        WR:      idx_r <= idx_r + IOne;
        default: ;
      endcase
      if (abort_i && active_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_engine.sv
// Self-checking bench for conv1d_engine: SRAM model with a bridge-side load port and
// a plain-arithmetic convolution reference computed from a memory snapshot.
module tb_conv1d_engine;
  localparam int NW  = 128;
  localparam int AW  = 7;
  localparam int KWB = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, sat;
  logic [AW-1:0] in_base, w_base, out_base;
  logic [AW:0]   in_len;
  logic [KWB-1:0] k_len;
  logic [5:0]    shift;
  logic          busy, done, err, ext_gnt, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, rdata;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic [31:0]   mem  [NW];
  logic [31:0]   snap [NW];

  int errs = 0;
  int checks = 0;
  int done_cyc, gnt_low, reqs, wrs, bad;
  logic err_seen;

  conv1d_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .in_base_i(in_base), .w_base_i(w_base), .out_base_i(out_base),
    .in_len_i(in_len), .k_len_i(k_len), .shift_i(shift), .sat_i(sat),
    .busy_o(busy), .done_o(done), .err_o(err), .ext_gnt_o(ext_gnt),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else rdata <= mem[mem_addr];
    end else if (ext_we) begin
      mem[ext_addr] <= ext_wdata;
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    ext_we = 1'b1; ext_addr = AW'(a); ext_wdata = d;
    @(negedge clk);
    ext_we = 1'b0;
  endtask

  function automatic logic [31:0] ref_y(input int i, input int k, input int xb, input int wb,
                                        input int sh, input bit s);
    logic signed [127:0] acc, a, b;
    acc = '0;
    for (int t = 0; t < k; t++) begin
      a = $signed(snap[wb+t]);
      b = $signed(snap[xb+i+t]);
      acc = acc + a * b;
    end
    acc = acc >>> sh;
    if (s && acc > 128'sd2147483647) return 32'h7FFFFFFF;
    if (s && acc < -128'sd2147483648) return 32'h80000000;
    return acc[31:0];
  endfunction

  function automatic int exp_done(input int k, input int n);
    return (k + 1) + ((k > 1) ? k : 0) + 3 * n + 1;
  endfunction

  // Drives one job, holding start high and scrambling config while busy; records observations.
  task automatic run_job(input int xb, input int wb, input int ob, input int len, input int k,
                         input int sh, input bit s, input int abort_at);
    for (int i = 0; i < NW; i++) snap[i] = mem[i];
    done_cyc = -1; gnt_low = 0; reqs = 0; wrs = 0; bad = 0; err_seen = 1'b0;
    @(negedge clk);
    in_base = AW'(xb); w_base = AW'(wb); out_base = AW'(ob); in_len = (AW+1)'(len);
    k_len = KWB'(k); shift = 6'(sh); sat = s; start = 1'b1;
    @(negedge clk);
    in_base = AW'($urandom); w_base = AW'($urandom); out_base = AW'($urandom);
    in_len = (AW+1)'($urandom); k_len = KWB'($urandom); shift = 6'($urandom); sat = 1'($urandom);
    for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      abort = (cyc == abort_at);
      #1;
      if (!ext_gnt) gnt_low++;
      if (busy == ext_gnt) bad++;
      if (mem_req && !busy) bad++;
      if (mem_req) reqs++;
      if (mem_we) wrs++;
      if (done) begin
        done_cyc = cyc; err_seen = err;
        if (busy || !ext_gnt || mem_req) bad++;
        start = 1'b0;
      end
    end
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    in_base = '0; w_base = '0; out_base = '0; in_len = '0; k_len = '0; shift = '0; sat = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, err, ext_gnt, mem_req, mem_we} !== 6'b000100) begin
      errs++; $display("FAIL reset_flags: got %b expected 000100", {busy, done, err, ext_gnt, mem_req, mem_we}); end
    checks++; if (mem_addr !== '0) begin errs++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, ext_gnt} !== 3'b001) begin
      errs++; $display("FAIL reset_release: got %b expected 001", {busy, done, ext_gnt}); end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 8; i++) poke(i, 32'(i));
    poke(100, 32'd1); poke(101, 32'd2); poke(102, 32'd1);
    for (int i = 0; i < 8; i++) poke(64 + i, 32'hDEAD_0000 + 32'(i));
    run_job(0, 100, 64, 8, 3, 0, 1'b0, 0);
    checks++; if (done_cyc !== 26) begin errs++; $display("FAIL basic_done: got %0d expected 26", done_cyc); end
    checks++; if (err_seen !== 1'b0) begin errs++; $display("FAIL basic_err: got %b expected 0", err_seen); end
    checks++; if (gnt_low !== 25) begin errs++; $display("FAIL basic_gnt: got %0d expected 25", gnt_low); end
    checks++; if (bad !== 0) begin errs++; $display("FAIL basic_handshake: got %0d violations expected 0", bad); end
    checks++; if (reqs !== 17) begin errs++; $display("FAIL basic_reqs: got %0d expected 17", reqs); end
    checks++; if (wrs !== 6) begin errs++; $display("FAIL basic_wrs: got %0d expected 6", wrs); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (mem[64+i] !== 32'(4 + 4 * i)) begin
        errs++; $display("FAIL basic_y%0d: got %0d expected %0d", i, mem[64+i], 4 + 4 * i); end
    end
    checks++; if (mem[70] !== 32'hDEAD_0006) begin errs++; $display("FAIL basic_tail: got %h expected dead0006", mem[70]); end
  endtask

  task automatic test_k1;
    poke(10, 32'd5); poke(11, -32'sd3); poke(12, 32'd0); poke(13, 32'd7); poke(110, -32'sd1);
    run_job(10, 110, 40, 4, 1, 0, 1'b0, 0);
    checks++; if (done_cyc !== 15) begin errs++; $display("FAIL k1_done: got %0d expected 15", done_cyc); end
    checks++; if (reqs !== 9) begin errs++; $display("FAIL k1_reqs: got %0d expected 9", reqs); end
    checks++; if (mem[40] !== -32'sd5) begin errs++; $display("FAIL k1_y0: got %h expected fffffffb", mem[40]); end
    checks++; if (mem[41] !== 32'd3) begin errs++; $display("FAIL k1_y1: got %h expected 3", mem[41]); end
    checks++; if (mem[42] !== 32'd0) begin errs++; $display("FAIL k1_y2: got %h expected 0", mem[42]); end
    checks++; if (mem[43] !== -32'sd7) begin errs++; $display("FAIL k1_y3: got %h expected fffffff9", mem[43]); end
  endtask

  task automatic test_saturation;
    poke(20, 32'h7FFFFFFF); poke(21, 32'h7FFFFFFF); poke(112, 32'h7FFFFFFF); poke(113, 32'h7FFFFFFF);
    run_job(20, 112, 50, 2, 2, 0, 1'b1, 0);
    checks++; if (done_cyc !== 9) begin errs++; $display("FAIL sat_done: got %0d expected 9", done_cyc); end
    checks++; if (mem[50] !== 32'h7FFFFFFF) begin errs++; $display("FAIL sat_on: got %h expected 7fffffff", mem[50]); end
    run_job(20, 112, 50, 2, 2, 0, 1'b0, 0);
    checks++; if (mem[50] !== 32'h2) begin errs++; $display("FAIL sat_off: got %h expected 2", mem[50]); end
  endtask

  task automatic test_shift;
    poke(22, -32'sd7); poke(23, 32'd0); poke(114, 32'd1); poke(115, 32'd1);
    run_job(22, 114, 51, 2, 2, 1, 1'b0, 0);
    checks++; if (mem[51] !== 32'hFFFFFFFC) begin errs++; $display("FAIL shift_y: got %h expected fffffffc", mem[51]); end
  endtask

  task automatic test_errors;
    int cfg [5][4] = '{'{0, 64, 16, 9}, '{0, 64, 2, 3}, '{0, 64, 4, 0}, '{120, 64, 10, 2}, '{0, 126, 8, 3}};
    for (int c = 0; c < 5; c++) begin
      run_job(cfg[c][0], 100, cfg[c][1], cfg[c][2], cfg[c][3], 0, 1'b0, 0);
      checks++; if (done_cyc !== 1 || err_seen !== 1'b1) begin
        errs++; $display("FAIL err%0d_status: got done@%0d err=%b expected done@1 err=1", c, done_cyc, err_seen); end
      checks++; if (reqs !== 0 || gnt_low !== 0) begin
        errs++; $display("FAIL err%0d_quiet: got reqs=%0d gnt_low=%0d expected 0 0", c, reqs, gnt_low); end
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 6; i++) poke(64 + i, 32'h5A5A_0000 + 32'(i));
    run_job(0, 100, 64, 8, 3, 0, 1'b0, 10);
    checks++; if (done_cyc !== 11 || err_seen !== 1'b1) begin
      errs++; $display("FAIL abort_status: got done@%0d err=%b expected done@11 err=1", done_cyc, err_seen); end
    checks++; if (wrs !== 0 || reqs !== 6) begin
      errs++; $display("FAIL abort_mem: got wrs=%0d reqs=%0d expected 0 6", wrs, reqs); end
    checks++; if (mem[64] !== 32'h5A5A_0000) begin errs++; $display("FAIL abort_nowrite: got %h expected 5a5a0000", mem[64]); end
    run_job(0, 100, 64, 8, 3, 0, 1'b0, 0);
    checks++; if (done_cyc !== 26 || err_seen !== 1'b0) begin
      errs++; $display("FAIL abort_rerun: got done@%0d err=%b expected done@26 err=0", done_cyc, err_seen); end
    checks++; if (mem[69] !== 32'd24) begin errs++; $display("FAIL abort_rerun_y5: got %0d expected 24", mem[69]); end
  endtask

  task automatic test_reset_mid_prime;
    int seen_done;
    @(negedge clk);
    in_base = '0; w_base = AW'(100); out_base = AW'(64); in_len = (AW+1)'(8); k_len = KWB'(3);
    shift = '0; sat = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err, ext_gnt, mem_req, mem_we} !== 6'b000100 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      errs++; $display("FAIL midreset_outputs: got %b addr=%0d wdata=%h expected 000100 0 0",
                       {busy, done, err, ext_gnt, mem_req, mem_we}, mem_addr, mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errs++; $display("FAIL midreset_idle: got %0d active cycles expected 0", seen_done); end
    run_job(0, 100, 64, 8, 3, 0, 1'b0, 0);
    checks++; if (done_cyc !== 26 || err_seen !== 1'b0) begin
      errs++; $display("FAIL midreset_rerun: got done@%0d err=%b expected done@26 err=0", done_cyc, err_seen); end
  endtask

  task automatic test_random;
    int k, len, xb, ob, sh, n;
    bit s;
    logic [31:0] e;
    for (int it = 0; it < 7; it++) begin
      if (it == 6) begin
        k = 8; len = 8; xb = 120; ob = 127; sh = $urandom_range(0, 40); s = 1'($urandom);
      end else begin
        k = $urandom_range(1, 8); len = $urandom_range(k, 20); xb = $urandom_range(0, 20);
        ob = (it % 2 == 0) ? xb : 64; sh = $urandom_range(0, 40); s = 1'($urandom);
      end
      n = len - k + 1;
      for (int i = 0; i < len; i++) poke(xb + i, ($urandom % 2) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100);
      for (int i = 0; i < k; i++) poke(100 + i, ($urandom % 2) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100);
      run_job(xb, 100, ob, len, k, sh, s, 0);
      checks++; if (done_cyc !== exp_done(k, n) || err_seen !== 1'b0) begin
        errs++; $display("FAIL rand%0d_done: got done@%0d err=%b expected done@%0d err=0", it, done_cyc, err_seen, exp_done(k, n)); end
      for (int i = 0; i < n; i++) begin
        e = ref_y(i, k, xb, 100, sh, s);
        checks++; if (mem[ob+i] !== e) begin
          errs++; $display("FAIL rand%0d_y%0d: got %h expected %h (k=%0d sh=%0d sat=%b)", it, i, mem[ob+i], e, k, sh, s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k1();
    test_saturation();
    test_shift();
    test_errors();
    test_abort();
    test_reset_mid_prime();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
